// File: rtl/ntlm_md4_feeder_if.sv
// Password byte stream, md4block link and hash result bundle
// for the NT-hash feeder.
interface ntlm_md4_feeder_if;
    logic         pw_valid;
    logic         pw_ready;
    logic [7:0]   pw_byte;
    logic         pw_last;
    logic [127:0] target;
    logic         md4_irdy;
    logic [31:0]  md4_state_a;
    logic [31:0]  md4_state_b;
    logic [31:0]  md4_state_c;
    logic [31:0]  md4_state_d;
    logic [511:0] md4_data;
    logic         md4_ordy;
    logic [31:0]  md4_newstate_a;
    logic [31:0]  md4_newstate_b;
    logic [31:0]  md4_newstate_c;
    logic [31:0]  md4_newstate_d;
    logic         hash_valid;
    logic [127:0] hash;
    logic         match;
    logic         err;

    modport master (
        output pw_valid, pw_byte, pw_last, target,
        output md4_ordy,
        output md4_newstate_a, md4_newstate_b,
        output md4_newstate_c, md4_newstate_d,
        input  pw_ready, md4_irdy, md4_data,
        input  md4_state_a, md4_state_b,
        input  md4_state_c, md4_state_d,
        input  hash_valid, hash, match, err
    );

    modport slave (
        input  pw_valid, pw_byte, pw_last, target,
        input  md4_ordy,
        input  md4_newstate_a, md4_newstate_b,
        input  md4_newstate_c, md4_newstate_d,
        output pw_ready, md4_irdy, md4_data,
        output md4_state_a, md4_state_b,
        output md4_state_c, md4_state_d,
        output hash_valid, hash, match, err
    );
endinterface

// File: rtl/ntlm_md4_feeder.sv
// Widens an ASCII password to UTF-16LE, builds the padded MD4 block,
// runs it through md4block and checks the NT hash against a target.
module ntlm_md4_feeder #(
    parameter int unsigned MAX_CHARS = 27,
    parameter int unsigned TIMEOUT   = 64
) (
    input logic              clk,
    input logic              rst,
    ntlm_md4_feeder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        WAIT,
        DONE
    } state_e;

    localparam logic [4:0] MaxC    = 5'(MAX_CHARS);
    localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

    state_e       state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic         ovf_q, ovf_d;
    logic [511:0] data_q, data_d;
    logic [7:0]   tmo_q, tmo_d;
    logic [127:0] hash_q, hash_d;
    logic         err_q, err_d;
    logic         ordy_q;
    logic         take;
    logic         rise;
    logic         append;

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign take   = bus.pw_valid && (state_q == IDLE);
    assign rise   = bus.md4_ordy && !ordy_q;
    assign append = !(bus.pw_last && (bus.pw_byte == 8'h00));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            data_q  <= '0;
            tmo_q   <= '0;
            hash_q  <= '0;
            err_q   <= 1'b0;
            ordy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
            hash_q  <= hash_d;
            err_q   <= err_d;
            ordy_q  <= bus.md4_ordy;
        end
    end

    // Block byte j lives at data[{~j, 3'b111} -: 8], i.e. 511-8j.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        data_d  = data_q;
        tmo_d   = tmo_q;
        hash_d  = hash_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (take) begin
                    if (append) begin
                        if (cnt_q < MaxC) begin
                            data_d[{~{cnt_q, 1'b0}, 3'b111} -: 8] = bus.pw_byte;
                            data_d[{~{cnt_q, 1'b1}, 3'b111} -: 8] = 8'h00;
                            cnt_d = cnt_q + 5'd1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (bus.pw_last) begin
                        if (ovf_d) begin
                            err_d  = 1'b1;
                            data_d = '0;
                            cnt_d  = '0;
                            ovf_d  = 1'b0;
                        end else begin
                            // 0x80 marker, then bit length 16n at bytes 56/57
                            data_d[{~{cnt_d, 1'b0}, 3'b111} -: 8] = 8'h80;
                            data_d[63:56] = {cnt_d[3:0], 4'h0};
                            data_d[55:48] = {7'h00, cnt_d[4]};
                            state_d = FIRE;
                        end
                    end
                end
            end
            FIRE: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (rise) begin
                    hash_d = {bswap(bus.md4_newstate_a),
                              bswap(bus.md4_newstate_b),
                              bswap(bus.md4_newstate_c),
                              bswap(bus.md4_newstate_d)};
                    state_d = DONE;
                end else if (tmo_q == TmoLast) begin
                    err_d   = 1'b1;
                    data_d  = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            DONE: begin
                data_d  = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.pw_ready   = 1'b0;
        bus.md4_irdy   = 1'b0;
        bus.hash_valid = 1'b0;
        bus.match      = 1'b0;
        unique case (state_q)
            IDLE: bus.pw_ready = 1'b1;
            FIRE: bus.md4_irdy = 1'b1;
            DONE: begin
                bus.hash_valid = 1'b1;
                bus.match      = (hash_q == bus.target);
            end
            default: ;
        endcase
    end

    assign bus.md4_state_a = 32'h67452301;
    assign bus.md4_state_b = 32'hEFCDAB89;
    assign bus.md4_state_c = 32'h98BADCFE;
    assign bus.md4_state_d = 32'h10325476;
    assign bus.md4_data    = data_q;
    assign bus.hash        = hash_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_ntlm_md4_feeder.sv
// Bench for ntlm_md4_feeder: table vectors, corner sequences and
// random passwords against an MD4 reference model.
module tb_ntlm_md4_feeder;

    localparam int MAXC     = 27;
    localparam int TMO      = 64;
    localparam int CORE_LAT = 50;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        string        pw;
        bit           term;
        bit           hit;
        logic [127:0] known;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   nvec = 0;
    int   nbad = 0;
    int   cyc = 0;
    int   last_acc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ntlm_md4_feeder_if bus ();

    ntlm_md4_feeder #(
        .MAX_CHARS(MAXC),
        .TIMEOUT  (TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic void chk(input string nm, input logic [511:0] act,
                                input logic [511:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Plain MD4 compression: returns IV + compress(IV, block) as {a,b,c,d}
    function automatic logic [127:0] md4_core(input logic [511:0] blk,
        input logic [31:0] ia, input logic [31:0] ib,
        input logic [31:0] ic, input logic [31:0] id);
        logic [31:0] x[16];
        logic [31:0] a, b, c, d, f, k, t, w;
        int sh[3][4];
        int o3[16];
        int s, idx, r, j;
        sh = '{'{3, 7, 11, 19}, '{3, 5, 9, 13}, '{3, 9, 11, 15}};
        o3 = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
        for (int i = 0; i < 16; i++) begin
            w = blk[511-32*i -: 32];
            x[i] = bswap(w);
        end
        a = ia; b = ib; c = ic; d = id;
        for (int i = 0; i < 48; i++) begin
            r = i / 16;
            j = i % 16;
            case (r)
                0: begin f = (b & c) | (~b & d); idx = j; k = 32'h0; end
                1: begin
                    f = (b & c) | (b & d) | (c & d);
                    idx = (j % 4) * 4 + j / 4;
                    k = 32'h5A827999;
                end
                default: begin f = b ^ c ^ d; idx = o3[j]; k = 32'h6ED9EBA1; end
            endcase
            s = sh[r][j%4];
            t = a + f + x[idx] + k;
            t = (t << s) | (t >> (32 - s));
            a = d; d = c; c = b; b = t;
        end
        return {a + ia, b + ib, c + ic, d + id};
    endfunction

    function automatic logic [511:0] ref_block(input bq_t pw);
        logic [7:0]   by[64];
        logic [63:0]  bits;
        logic [511:0] blk;
        int n;
        n = pw.size();
        for (int i = 0; i < 64; i++) by[i] = 8'h00;
        for (int i = 0; i < n; i++) by[2*i] = pw[i];
        by[2*n] = 8'h80;
        bits = 64'(16 * n);
        for (int i = 0; i < 8; i++) by[56+i] = bits[8*i +: 8];
        for (int i = 0; i < 64; i++) blk[511-8*i -: 8] = by[i];
        return blk;
    endfunction

    function automatic logic [127:0] ref_hash(input bq_t pw);
        logic [127:0] st;
        st = md4_core(ref_block(pw), 32'h67452301, 32'hEFCDAB89,
                      32'h98BADCFE, 32'h10325476);
        return {bswap(st[127:96]), bswap(st[95:64]),
                bswap(st[63:32]), bswap(st[31:0])};
    endfunction

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // md4block stand-in: ordy rises CORE_LAT cycles after irdy and
    // stays high until shortly after the next irdy.
    logic         core_ordy = 1'b0;
    logic [127:0] core_ns = '0;
    int           core_cnt = 0;
    int           core_drop = 0;
    bit           core_hang = 1'b0;

    assign bus.md4_ordy       = core_ordy;
    assign bus.md4_newstate_a = core_ns[127:96];
    assign bus.md4_newstate_b = core_ns[95:64];
    assign bus.md4_newstate_c = core_ns[63:32];
    assign bus.md4_newstate_d = core_ns[31:0];

    always @(posedge clk) begin
        if (bus.md4_irdy && !core_hang) core_cnt <= CORE_LAT;
        else if (core_cnt > 0) core_cnt <= core_cnt - 1;
        if (bus.md4_irdy) core_drop <= 2;
        else if (core_drop > 0) core_drop <= core_drop - 1;
        if (core_cnt == 1) begin
            core_ordy <= 1'b1;
            core_ns   <= md4_core(bus.md4_data, bus.md4_state_a,
                                  bus.md4_state_b, bus.md4_state_c,
                                  bus.md4_state_d);
        end else if (core_drop == 1) begin
            core_ordy <= 1'b0;
        end
    end

    int           irdy_cq[$];
    logic [511:0] irdy_dq[$];
    logic [127:0] hv_hq[$];
    bit           hv_mq[$];
    int           err_cq[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.md4_irdy) begin
                irdy_cq.push_back(cyc);
                irdy_dq.push_back(bus.md4_data);
                chk("rdy_in_fire", 512'(bus.pw_ready), 512'd0);
                chk("iv", 512'({bus.md4_state_a, bus.md4_state_b,
                                bus.md4_state_c, bus.md4_state_d}),
                    512'(128'h67452301EFCDAB8998BADCFE10325476));
            end
            if (bus.hash_valid) begin
                hv_hq.push_back(bus.hash);
                hv_mq.push_back(bus.match);
                chk("rdy_in_done", 512'(bus.pw_ready), 512'd0);
            end
            if (bus.err) err_cq.push_back(cyc);
        end
    end

    task automatic clear_mon();
        irdy_cq.delete();
        irdy_dq.delete();
        hv_hq.delete();
        hv_mq.delete();
        err_cq.delete();
    endtask

    task automatic put(input logic [7:0] b, input bit last, input bit gap);
        int n = 0;
        @(negedge clk);
        if (gap) begin
            bus.pw_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        bus.pw_valid = 1'b1;
        bus.pw_byte  = b;
        bus.pw_last  = last;
        while (!bus.pw_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.pw_ready) chk("pw_ready_wait", 512'd0, 512'd1);
        last_acc = cyc;
        @(posedge clk);
    endtask

    task automatic send_pw(input bq_t pw, input bit term, input bit gaps);
        for (int i = 0; i < pw.size(); i++)
            put(pw[i], (i == pw.size() - 1) && !term,
                gaps && ($urandom_range(0, 2) == 0));
        if (term) put(8'h00, 1'b1, 1'b0);
    endtask

    task automatic wait_res(input int want, input int budget);
        int w = 0;
        while ((hv_hq.size() + err_cq.size()) < want && w < budget) begin
            @(negedge clk);
            w++;
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic job(input string nm, input bq_t pw, input bit term,
                       input bit gaps, input bit hit, input logic [127:0] known);
        logic [127:0] eh;
        logic [511:0] d;
        bit           ovf;
        ovf = pw.size() > MAXC;
        eh  = ovf ? 128'h0 : ((known != 0) ? known : ref_hash(pw));
        bus.target = hit ? eh : ~eh;
        clear_mon();
        send_pw(pw, term, gaps);
        @(negedge clk);
        bus.pw_valid = 1'b0;
        wait_res(1, 200);
        chk({nm, "_rdy_after"}, 512'(bus.pw_ready), 512'd1);
        if (ovf) begin
            chk({nm, "_err_n"}, 512'(err_cq.size()), 512'd1);
            chk({nm, "_irdy_n"}, 512'(irdy_cq.size()), 512'd0);
            chk({nm, "_hv_n"}, 512'(hv_hq.size()), 512'd0);
            if (err_cq.size() > 0)
                chk({nm, "_err_lat"}, 512'(err_cq[0] - last_acc), 512'd1);
        end else begin
            chk({nm, "_irdy_n"}, 512'(irdy_cq.size()), 512'd1);
            chk({nm, "_hv_n"}, 512'(hv_hq.size()), 512'd1);
            chk({nm, "_err_n"}, 512'(err_cq.size()), 512'd0);
            if (irdy_cq.size() > 0) begin
                d = irdy_dq[0];
                chk({nm, "_irdy_lat"}, 512'(irdy_cq[0] - last_acc), 512'd1);
                chk({nm, "_data"}, d, ref_block(pw));
                if (pw.size() == MAXC)
                    chk({nm, "_b54_56_57"},
                        512'({d[511-8*54 -: 8], d[511-8*56 -: 8], d[511-8*57 -: 8]}),
                        512'(24'h80B001));
            end
            if (hv_hq.size() > 0) begin
                chk({nm, "_hash"}, 512'(hv_hq[0]), 512'(eh));
                chk({nm, "_match"}, 512'(hv_mq[0]), 512'(hit));
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t         tbl[6];
        bq_t          pa, pb, pr;
        logic [511:0] d;
        int           len;

        tbl[0] = '{"password", 1'b0, 1'b1, 128'h8846F7EAEE8FB117AD06BDD830B7586C};
        tbl[1] = '{"", 1'b1, 1'b1, 128'h31D6CFE0D16AE931B73C59D7E0C089C0};
        tbl[2] = '{"abcdefghijklmnopqrstuvwxyz0", 1'b0, 1'b1, 128'h0};
        tbl[3] = '{"abcdefghijklmnopqrstuvwxyz01", 1'b0, 1'b0, 128'h0};
        tbl[4] = '{"password", 1'b1, 1'b0, 128'h8846F7EAEE8FB117AD06BDD830B7586C};
        tbl[5] = '{"Z", 1'b0, 1'b1, 128'h0};

        rst = 1'b1;
        bus.pw_valid = 1'b0;
        bus.pw_byte  = 8'h00;
        bus.pw_last  = 1'b0;
        bus.target   = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 512'(bus.pw_ready), 512'd1);
        chk("rst_flags", 512'({bus.md4_irdy, bus.hash_valid, bus.match, bus.err}),
            512'd0);
        chk("rst_hash", 512'(bus.hash), 512'd0);
        chk("rst_data", bus.md4_data, 512'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++)
            job($sformatf("tbl%0d", i), str2q(tbl[i].pw), tbl[i].term, 1'b0,
                tbl[i].hit, tbl[i].known);

        // core never answers: error after the timeout, no hash
        core_hang = 1'b1;
        clear_mon();
        send_pw(str2q("abc"), 1'b0, 1'b0);
        @(negedge clk);
        bus.pw_valid = 1'b0;
        wait_res(1, 200);
        core_hang = 1'b0;
        chk("tmo_err_n", 512'(err_cq.size()), 512'd1);
        chk("tmo_hv_n", 512'(hv_hq.size()), 512'd0);
        chk("tmo_rdy", 512'(bus.pw_ready), 512'd1);
        if (err_cq.size() > 0 && irdy_cq.size() > 0)
            chk("tmo_lat", 512'(err_cq[0] - irdy_cq[0]), 512'(TMO + 1));

        // reset in WAIT; the late ordy must be ignored
        clear_mon();
        send_pw(str2q("resetme"), 1'b0, 1'b0);
        @(negedge clk);
        bus.pw_valid = 1'b0;
        for (int w = 0; w < 20 && irdy_cq.size() == 0; w++) @(negedge clk);
        chk("rstw_irdy_n", 512'(irdy_cq.size()), 512'd1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_rdy", 512'(bus.pw_ready), 512'd1);
        chk("rstw_hash", 512'(bus.hash), 512'd0);
        chk("rstw_data", bus.md4_data, 512'd0);
        repeat (80) @(negedge clk);
        chk("rstw_hv_n", 512'(hv_hq.size()), 512'd0);
        chk("rstw_err_n", 512'(err_cq.size()), 512'd0);
        job("after_rst", str2q("password"), 1'b0, 1'b0, 1'b1,
            128'h8846F7EAEE8FB117AD06BDD830B7586C);

        // back-to-back with pw_valid held high, target mismatched
        pa = str2q("hunter2");
        pb = str2q("Secret!9");
        bus.target = 128'h0123456789ABCDEF0123456789ABCDEF;
        clear_mon();
        send_pw(pa, 1'b0, 1'b0);
        send_pw(pb, 1'b0, 1'b0);
        @(negedge clk);
        bus.pw_valid = 1'b0;
        wait_res(2, 300);
        chk("b2b_irdy_n", 512'(irdy_cq.size()), 512'd2);
        chk("b2b_hv_n", 512'(hv_hq.size()), 512'd2);
        if (hv_hq.size() == 2) begin
            chk("b2b_hash0", 512'(hv_hq[0]), 512'(ref_hash(pa)));
            chk("b2b_hash1", 512'(hv_hq[1]), 512'(ref_hash(pb)));
            chk("b2b_match", 512'({hv_mq[0], hv_mq[1]}), 512'd0);
        end
        if (irdy_dq.size() == 2) begin
            d = irdy_dq[1];
            chk("b2b_data1", d, ref_block(pb));
        end

        for (int i = 0; i < 25; i++) begin
            pr.delete();
            len = $urandom_range(0, 29);
            for (int k = 0; k < len; k++) pr.push_back(8'($urandom_range(32, 126)));
            job($sformatf("rnd%0d", i), pr, (len == 0) ? 1'b1 : 1'($urandom_range(0, 1)),
                1'b1, 1'($urandom_range(0, 1)), 128'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
